alu_display: RTL



---
 rtl/alu_display.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/alu_display.sv
// alu_display
//   Output stage behind the ALU. A Start pulse captures the 8-bit Sal value.
//   A sequential shift-and-add-3 engine then converts it to three BCD digits.
//   The result is shown on a time-multiplexed, common-anode 3-digit
//   7-segment display with leading-zero blanking.
//
// Ports
//   Clk    : system clock, rising edge
//   Rst_n  : asynchronous active-low reset
//   Start  : conversion request, only honoured while idle
//   Sal    : unsigned 8-bit value to convert
//   Busy   : high while the shift engine runs
//   Done   : single-cycle pulse when Bcd has been updated
//   Bcd    : registered result {hundreds, tens, units}
//   Seg    : active-low segments {g,f,e,d,c,b,a}
//   An     : active-low one-hot digit enables, An[0] = units
module alu_display #(
   parameter int REFRESH_CNT = 50000
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Start,
   input  logic [7:0]  Sal,
   output logic        Busy,
   output logic        Done,
   output logic [11:0] Bcd,
   output logic [6:0]  Seg,
   output logic [2:0]  An
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [15:0] REFRESH_LAST = 16'(REFRESH_CNT - 1);

   state_t      state_reg;
   logic [19:0] work_reg;
   logic [2:0]  shift_cnt_reg;
   logic        busy_reg;
   logic        done_reg;
   logic [11:0] bcd_reg;

   logic [19:0] work_adj;
   logic [19:0] work_shift;

   // Each BCD nibble is corrected from the pre-edge value before the shift.
   assign work_adj[7:0] = work_reg[7:0];

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_adj
         logic [3:0] nib;
         assign nib = work_reg[8 + 4*gi +: 4];
         assign work_adj[8 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
      end
   endgenerate

   assign work_shift = work_adj << 1;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_reg     <= IDLE;
         work_reg      <= '0;
         shift_cnt_reg <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         bcd_reg       <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (Start) begin
                  work_reg      <= {12'h000, Sal};
                  shift_cnt_reg <= '0;
                  busy_reg      <= 1'b1;
                  state_reg     <= SHIFT;
               end
            end
            SHIFT: begin
               work_reg      <= work_shift;
               shift_cnt_reg <= shift_cnt_reg + 3'd1;
               // Eighth shift: the BCD field is complete, publish it directly.
               if (shift_cnt_reg == 3'd7) begin
                  bcd_reg   <= work_shift[19:8];
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign Busy = busy_reg;
   assign Done = done_reg;
   assign Bcd  = bcd_reg;

   // ---------------- display scan ----------------
   logic [15:0] refresh_reg;
   logic [1:0]  digit_reg;
   logic [1:0]  digit_next;
   logic        refresh_wrap;
   logic [3:0]  digit_val;
   logic        digit_blank;
   logic [6:0]  seg_next;
   logic [2:0]  an_next;
   logic [6:0]  seg_reg;
   logic [2:0]  an_reg;

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    seg_decode = 7'b1000000;
         4'd1:    seg_decode = 7'b1111001;
         4'd2:    seg_decode = 7'b0100100;
         4'd3:    seg_decode = 7'b0110000;
         4'd4:    seg_decode = 7'b0011001;
         4'd5:    seg_decode = 7'b0010010;
         4'd6:    seg_decode = 7'b0000010;
         4'd7:    seg_decode = 7'b1111000;
         4'd8:    seg_decode = 7'b0000000;
         4'd9:    seg_decode = 7'b0010000;
         default: seg_decode = 7'b1111111;
      endcase
   endfunction

   assign refresh_wrap = (refresh_reg == REFRESH_LAST);

   // Seg/An are computed for the digit that will be active after this edge,
   // so both registers switch together and Seg tracks Bcd one cycle later.
   always_comb begin
      digit_next = digit_reg;
      if (refresh_wrap)
         digit_next = (digit_reg == 2'd2) ? 2'd0 : digit_reg + 2'd1;

      digit_val   = bcd_reg[3:0];
      digit_blank = 1'b0;
      an_next     = 3'b110;
      case (digit_next)
         2'd1: begin
            digit_val   = bcd_reg[7:4];
            digit_blank = (bcd_reg[11:8] == 4'd0) && (bcd_reg[7:4] == 4'd0);
            an_next     = 3'b101;
         end
         2'd2: begin
            digit_val   = bcd_reg[11:8];
            digit_blank = (bcd_reg[11:8] == 4'd0);
            an_next     = 3'b011;
         end
         default: ;
      endcase
      seg_next = digit_blank ? 7'b1111111 : seg_decode(digit_val);
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         refresh_reg <= '0;
         digit_reg   <= '0;
         an_reg      <= 3'b110;
         seg_reg     <= 7'b1000000;
      end else begin
         refresh_reg <= refresh_wrap ? 16'd0 : refresh_reg + 16'd1;
         digit_reg   <= digit_next;
         an_reg      <= an_next;
         seg_reg     <= seg_next;
      end
   end

   assign Seg = seg_reg;
   assign An  = an_reg;

endmodule
